// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-2 Booth multiplier producing the full
// 2*WIDTH product (hi/result), one Booth step per clock.
// Optional build macro BOOTH_MUL_SEQ_ZERO_SKIP_EN: a zero operand skips RUN
// and the result is ready the cycle after the accepting edge.
//
// Handshake: a request is taken on a clk edge where start=1 and busy=0
// (IDLE or DONE). busy is high only while iterating. done is a one-cycle
// pulse, and hi/result/of_flag are valid in that cycle. Those outputs hold
// until the next DONE load. start while busy=1 is dropped, not queued.
// flush aborts RUN without raising done. flush has no effect when busy=0.
module booth_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] result,
  output logic             of_flag,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, mq, mcand;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic             smode;

  logic [WIDTH:0]   a_ext, b_ext, sum, acc_sh, mq_sh;
  logic             q1_sh, accept, last, skip, of_calc;
  logic [WIDTH-1:0] prod_hi, prod_lo;

  // Operand extension, one Booth add/sub, shift, and product/overflow view.
  always_comb begin
    a_ext   = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext   = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
    sum     = acc;
    case ({mq[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_sh  = {sum[WIDTH], sum[WIDTH:1]};
    mq_sh   = {sum[0], mq[WIDTH:1]};
    q1_sh   = mq[0];
    prod_lo = mq_sh[WIDTH-1:0];
    prod_hi = {acc_sh[WIDTH-2:0], mq_sh[WIDTH]};
    of_calc = smode ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}})
                    : (prod_hi != '0);
    accept  = start && (state != RUN);
    last    = (cnt == CNT_W'(1));
`ifdef BOOTH_MUL_SEQ_ZERO_SKIP_EN
    skip    = (a_ext == '0) || (b_ext == '0);
`else
    skip    = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush only matters while iterating.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = skip ? DONE : RUN;
      RUN: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = skip ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one Booth step per RUN edge, publish on last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      smode   <= 1'b0;
      hi      <= '0;
      result  <= '0;
      of_flag <= 1'b0;
    end else if (accept) begin
      acc   <= '0;
      mq    <= b_ext;
      q_1   <= 1'b0;
      mcand <= a_ext;
      smode <= signed_mode;
      if (skip) begin
        cnt     <= '0;
        hi      <= '0;
        result  <= '0;
        of_flag <= 1'b0;
      end else begin
        cnt <= CNT_INIT;
      end
    end else if (state == RUN && !flush) begin
      acc <= acc_sh;
      mq  <= mq_sh;
      q_1 <= q1_sh;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        hi      <= prod_hi;
        result  <= prod_lo;
        of_flag <= of_calc;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed vector table plus hand-written multi-cycle
// sequences (ignored start, back-to-back, flush, async reset mid-run).
module tb_booth_mul_seq;

  localparam int W = 32;
`ifdef BOOTH_MUL_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  localparam int LAT  = W + 2;
  localparam int BUSY = W + 1;

  logic         clk, rst, start, signed_mode, flush;
  logic [W-1:0] a, b, hi, result;
  logic         busy, done, of_flag;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  booth_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .result(result), .of_flag(of_flag), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         of;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request and let the next edge accept it; returns at #1 after that edge.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm);
    start = 1'b1; a = av; b = bv; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edge count includes the accepting edge (e0 edges already elapsed).
  task automatic wait_done(input int e0, output int edges, output int bc);
    edges = e0; bc = 0;
    while (!done && edges < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic watch_no_done(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int edges, bc;
    logic zero;

    vecs[0]  = '{32'd3,        32'd5,        1'b0, 32'h0,        32'hF,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'h3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h1,        1'b0};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0,        1'b1};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1,        1'b1};
    vecs[5]  = '{32'h80000000, 32'h2,        1'b0, 32'h1,        32'h0,        1'b1};
    vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001, 1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'h5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h1,        1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[9]  = '{32'h0,        32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{32'h1234,     32'h0,        1'b1, 32'h0,        32'h0,        1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_busy",   64'(busy),      64'd0);
    check("reset_done",   64'(done),      64'd0);
    check("reset_hi",     64'(hi),        64'd0);
    check("reset_result", 64'(result),    64'd0);
    check("reset_of",     64'(of_flag),   64'd0);
    check("reset_state",  64'(state_dbg), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      zero = (vecs[i].a == '0) || (vecs[i].b == '0);
      accept_op(vecs[i].a, vecs[i].b, vecs[i].sm);
      wait_done(1, edges, bc);
      check($sformatf("v%0d_latency", i), 64'(edges), (ZS && zero) ? 64'd1 : 64'(LAT));
      check($sformatf("v%0d_busy_cycles", i), 64'(bc), (ZS && zero) ? 64'd0 : 64'(BUSY));
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].lo));
      check($sformatf("v%0d_of", i), 64'(of_flag), 64'(vecs[i].of));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("v%0d_idle", i), 64'(state_dbg), 64'd0);
    end

    // start during RUN is ignored; start in DONE is accepted back-to-back
    accept_op(32'd2, 32'd2, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    wait_done(11, edges, bc);
    check("ign_latency", 64'(edges), 64'(LAT));
    check("ign_result",  64'(result), 64'd4);
    check("ign_hi",      64'(hi),     64'd0);
    accept_op(32'd9, 32'd9, 1'b0);
    check("b2b_busy",        64'(busy),   64'd1);
    check("b2b_result_hold", 64'(result), 64'd4);
    wait_done(1, edges, bc);
    check("b2b_latency", 64'(edges),  64'(LAT));
    check("b2b_result",  64'(result), 64'd81);

    // flush in RUN: back to IDLE, no done, outputs held
    @(posedge clk); #1;
    accept_op(32'd7, 32'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", 64'(state_dbg), 64'd0);
    check("flush_busy",  64'(busy),      64'd0);
    watch_no_done(40, "flush_no_done");
    check("flush_result_hold", 64'(result), 64'd81);
    check("flush_hi_hold",     64'(hi),     64'd0);

    // flush with start while idle: start is accepted
    flush = 1'b1;
    accept_op(32'd6, 32'd7, 1'b0);
    flush = 1'b0;
    check("flush_idle_accept", 64'(busy), 64'd1);
    wait_done(1, edges, bc);
    check("flush_idle_latency", 64'(edges),  64'(LAT));
    check("flush_idle_result",  64'(result), 64'd42);

    // async reset mid-RUN
    @(posedge clk); #1;
    accept_op(32'h11111111, 32'd3, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_busy",   64'(busy),    64'd0);
    check("rst_done",   64'(done),    64'd0);
    check("rst_result", 64'(result),  64'd0);
    check("rst_hi",     64'(hi),      64'd0);
    check("rst_of",     64'(of_flag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    watch_no_done(40, "rst_no_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
